multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/instr_counter.sv | 19 +
 rtl/multicycle_control.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path:
// FSM state codes, opcodes, ALU op codes and the control bundle.
package mips_pkg;

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] RWB    = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] JUMP   = 4'd9;
  localparam logic [3:0] ADDIEX = 4'd10;
  localparam logic [3:0] ADDIWB = 4'd11;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] ADDI  = 6'b001000;

  localparam logic [1:0] ADD   = 2'b00;
  localparam logic [1:0] SUB   = 2'b01;
  localparam logic [1:0] FUNCT = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic       alusrca;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic [1:0] alusrcb;
  } ctrl_t;

  // States whose exit completes an instruction.
  function automatic logic retires(input logic [3:0] s);
    return (s == MEMWB) || (s == MEMWR) || (s == RWB) ||
           (s == BRANCH) || (s == JUMP) || (s == ADDIWB);
  endfunction

endpackage

// File: rtl/instr_counter.sv
// Retired-instruction counter, wraps from all-ones to zero.
// Ports: clk, reset (sync, high), inc, count[CNT_W-1:0].
module instr_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM (Moore) with retired counter.
// Ports: clk, reset, opcode, zero in; strobes/selects, pc_en,
// illegal, retired, state out.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             AluSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       AluOp,
  output logic [1:0]       AluSrcB,
  output logic             pc_en,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  logic [3:0] st;
  logic [3:0] nxt;
  logic       ill;
  ctrl_t      c;

  always_ff @(posedge clk) begin
    if (reset)
      st <= FETCH;
    else
      st <= nxt;
  end

  // opcode is only looked at in DECODE and MEMADR.
  always_comb begin
    nxt = FETCH;
    ill = 1'b0;
    case (st)
      FETCH:  nxt = DECODE;
      DECODE: begin
        unique case (1'b1)
          (opcode == RTYPE): nxt = EXEC;
          (opcode == LW),
          (opcode == SW):    nxt = MEMADR;
          (opcode == BEQ):   nxt = BRANCH;
          (opcode == J):     nxt = JUMP;
          (opcode == ADDI):  nxt = ADDIEX;
          default: begin
            nxt = FETCH;
            ill = 1'b1;
          end
        endcase
      end
      MEMADR: nxt = (opcode == LW) ? MEMRD : MEMWR;
      MEMRD:  nxt = MEMWB;
      EXEC:   nxt = RWB;
      ADDIEX: nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    case (st)
      FETCH: begin
        c.memread = 1'b1;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
        c.aluop   = ADD;
      end
      DECODE: begin
        c.alusrcb = 2'b11;
        c.aluop   = ADD;
      end
      MEMADR, ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = ADD;
      end
      MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = FUNCT;
      end
      RWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      BRANCH: begin
        c.pcwritecond = 1'b1;
        c.alusrca     = 1'b1;
        c.aluop       = SUB;
        c.pcsource    = 2'b01;
      end
      JUMP: begin
        c.pcwrite  = 1'b1;
        c.pcsource = 2'b10;
      end
      ADDIWB: c.regwrite = 1'b1;
      default: c = '0;
    endcase
  end

  assign PCWrite     = c.pcwrite;
  assign PCWriteCond = c.pcwritecond;
  assign IorD        = c.iord;
  assign MemRead     = c.memread;
  assign MemWrite    = c.memwrite;
  assign MemtoReg    = c.memtoreg;
  assign IRWrite     = c.irwrite;
  assign AluSrcA     = c.alusrca;
  assign RegWrite    = c.regwrite;
  assign RegDst      = c.regdst;
  assign PCSource    = c.pcsource;
  assign AluOp       = c.aluop;
  assign AluSrcB     = c.alusrcb;

  // zero only matters while PCWriteCond is up, i.e. in BRANCH.
  assign pc_en   = c.pcwrite | (c.pcwritecond & zero);
  assign illegal = ill;
  assign state   = st;

  instr_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (retires(st)),
    .count (retired)
  );

endmodule
